// File: rtl/micro_core_pkg.sv
// micro_core_pkg: shared ISA encoding, write-select codes, FSM states and decode helpers
// Instruction word layout (MSB..LSB): {B, C, WS[1:0], OP[4:0], A1[4:0], A2[4:0], CONST[7:0], WA[4:0]}
package micro_core_pkg;
  localparam logic [1:0] WS_NONE = 2'd0;
  localparam logic [1:0] WS_IN   = 2'd1;
  localparam logic [1:0] WS_SE   = 2'd2;
  localparam logic [1:0] WS_ALU  = 2'd3;
  // 23-bit immediate {OP,A1,A2,CONST} used by WS_SE
  localparam int IMM_MSB = 27;
  localparam int IMM_LSB = 5;
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  typedef struct packed {
    logic       b;
    logic       c;
    logic [1:0] ws;
    logic [4:0] op;
    logic [4:0] a1;
    logic [4:0] a2;
    logic [7:0] cst;
    logic [4:0] wa;
  } instr_t;
  function automatic logic is_out_instr(instr_t i);
    return i.ws == WS_NONE && !i.b && !i.c && i.op == 5'd0;
  endfunction
  // Unconditional jump-to-self is the halt idiom
  function automatic logic is_halt(instr_t i);
    return i.b && i.cst == 8'd0;
  endfunction
endpackage

// File: rtl/ALU_RiscV.sv
// ALU_RiscV: 32-bit RISC-V style ALU; Result for arithmetic ops, Flag for compare ops
// Ports: A, B operands; ALUOp operation select; Result value; Flag branch condition
module ALU_RiscV (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUOp,
  output logic [31:0] Result,
  output logic        Flag
);
  always_comb begin
    Result = '0;
    Flag   = 1'b0;
    case (ALUOp)
      5'b00000: Result = A + B;
      5'b01000: Result = A - B;
      5'b00100: Result = A ^ B;
      5'b00110: Result = A | B;
      5'b00111: Result = A & B;
      5'b00001: Result = A << B[4:0];
      5'b00101: Result = A >> B[4:0];
      5'b01101: Result = $signed(A) >>> B[4:0];
      5'b00010: Result = {31'd0, $signed(A) < $signed(B)};
      5'b00011: Result = {31'd0, A < B};
      5'b11000: Flag = A == B;
      5'b11001: Flag = A != B;
      5'b11100: Flag = $signed(A) < $signed(B);
      5'b11101: Flag = $signed(A) >= $signed(B);
      5'b11110: Flag = A < B;
      5'b11111: Flag = A >= B;
      default: ;
    endcase
  end
endmodule

// File: rtl/micro_core_regfile.sv
// micro_core_regfile: REG_N x DATA_W register file, 2 async reads, 1 sync write, r0 hardwired 0
// Ports: clk, reset (async, active-high); ra1/ra2 read addresses -> rd1/rd2; we/wa/wd write port
// Addresses >= REG_N read as 0 and ignore writes; reads see the old value during a write.
module micro_core_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);
  localparam logic [5:0] LIM = 6'(REG_N);
  logic [DATA_W-1:0] regs [32];
  assign rd1 = (ra1 != 5'd0 && {1'b0, ra1} < LIM) ? regs[ra1] : '0;
  assign rd2 = (ra2 != 5'd0 && {1'b0, ra2} < LIM) ? regs[ra2] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0 && {1'b0, wa} < LIM)
      regs[wa] <= wd;
endmodule

// File: rtl/micro_core_hs.sv
// micro_core_hs: single-issue core with valid/ready IN/OUT handshakes, buffered output and HALT state
// Ports: clk; reset (async, active-high); imem_addr/imem_data instruction ROM; in_data/in_valid/in_ready
//   input handshake; out_data/out_valid/out_ready buffered output handshake; halted status.
// Option: define RETIRE_CNT_EN to add the 32-bit retire_cnt output counting retired instructions.
module micro_core_hs
  import micro_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);
  instr_t ins;
  state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic [DATA_W-1:0] rd1, rd2, wd;
  logic [31:0] alu_res;
  logic alu_flag, run, out_i, stall, retire, we;
  assign ins = instr_t'(imem_data);
  assign imem_addr = pc;
  assign run = state == ST_RUN;
  assign out_i = is_out_instr(ins);
  // An OUT may retire while the buffer is full only if the sink takes the old value this cycle
  assign stall = (ins.ws == WS_IN && !in_valid) || (out_i && out_valid && !out_ready);
  assign retire = run && !stall;
  assign we = retire && ins.ws != WS_NONE;
  assign wd = ins.ws == WS_IN ? in_data :
              ins.ws == WS_SE ? DATA_W'($signed(imem_data[IMM_MSB:IMM_LSB])) :
              DATA_W'(alu_res);
  micro_core_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk(clk), .reset(reset), .ra1(ins.a1), .ra2(ins.a2),
    .we(we), .wa(ins.wa), .wd(wd), .rd1(rd1), .rd2(rd2)
  );
  ALU_RiscV u_alu (.A(rd1[31:0]), .B(rd2[31:0]), .ALUOp(ins.op), .Result(alu_res), .Flag(alu_flag));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_RUN;
    else state <= state_nx;
  always_comb state_nx = (retire && is_halt(ins)) ? ST_HALT : state;
  always_comb begin
    halted = state == ST_HALT;
    in_ready = run && ins.ws == WS_IN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (retire) pc <= pc + ((ins.b || (ins.c && alu_flag)) ? PC_W'($signed(ins.cst)) : PC_W'(1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_data <= '0;
      out_valid <= 1'b0;
    end else if (retire && out_i) begin
      out_data <= rd1;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
`endif
endmodule
